// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: debounces a scanned 4-digit 7-segment bus and reassembles one BCD word per full scan frame
module seg7_scan_decoder #(
    parameter int STABLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  dig,
    input  logic [6:0]  seg,
    output logic [15:0] bcd,
    output logic        err,
    output logic        valid
);
    localparam logic [3:0] ST  = 4'(STABLE);
    localparam logic [3:0] ST1 = 4'(STABLE - 1);
    logic [10:0]     prev;
    logic [3:0]      cnt, mask, code, fl, fl_n;
    logic [3:0][3:0] sh, sh_n;
    logic            same, onehot, cap, full;
    always_comb begin
        case (seg)
            7'b1111110: code = 4'd0;
            7'b0110000: code = 4'd1;
            7'b1101101: code = 4'd2;
            7'b1111001: code = 4'd3;
            7'b0110011: code = 4'd4;
            7'b1011011: code = 4'd5;
            7'b1011111: code = 4'd6;
            7'b1110000: code = 4'd7;
            7'b1111111: code = 4'd8;
            7'b1111011: code = 4'd9;
            7'b0000000: code = 4'hF;
            default:    code = 4'hE;
        endcase
    end
    assign same   = {dig, seg} == prev;
    assign onehot = dig != 4'd0 && (dig & (dig - 4'd1)) == 4'd0;
    assign cap    = same && cnt == ST1 && onehot;
    assign full   = cap && (mask | dig) == 4'hF;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sh_n[i] = cap && dig[i] ? code : sh[i];
            fl_n[i] = cap && dig[i] ? code == 4'hE : fl[i];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            cnt   <= '0;
            mask  <= '0;
            sh    <= '0;
            fl    <= '0;
            bcd   <= '0;
            err   <= 1'b0;
            valid <= 1'b0;
        end else begin
            prev  <= {dig, seg};
            cnt   <= !same ? 4'd1 : cnt < ST ? cnt + 4'd1 : cnt;
            valid <= full;
            if (cap) begin
                sh   <= sh_n;
                fl   <= fl_n;
                mask <= full ? 4'd0 : mask | dig;
            end
            if (full) begin
                bcd <= sh_n;
                err <= |fl_n;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed frames checked every cycle against a run-length model plus literal expectations
module tb_seg7_scan_decoder;
    localparam int STABLE = 4;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001,
                           S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000, S9 = 7'b1111011;
    logic        clk = 0, rst;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic        err, valid;
    int          cmp = 0, mis = 0;
    int          ecnt = 0, vcnt = 0, vedge = 0;
    seg7_scan_decoder #(.STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .dig(dig), .seg(seg), .bcd(bcd), .err(err), .valid(valid)
    );
    always #5 clk = ~clk;
    logic [6:0]  pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [10:0] m_last;
    int          run;
    logic [3:0]  m_code [4];
    logic [3:0]  m_seen;
    logic [15:0] m_bcd;
    logic        m_err, m_valid;
    function automatic logic [3:0] dec(input logic [6:0] s);
        if (s == 7'd0) return 4'hF;
        for (int i = 0; i < 10; i++) if (pat[i] == s) return 4'(i);
        return 4'hE;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, ecnt);
        end
    endtask
    always @(posedge clk) begin
        ecnt++;
        if (rst) begin
            m_last = '0; run = 0; m_seen = '0; m_bcd = '0; m_err = 0; m_valid = 0;
            for (int i = 0; i < 4; i++) m_code[i] = '0;
        end else begin
            run = ({dig, seg} == m_last) ? run + 1 : 1;
            m_last = {dig, seg};
            m_valid = 0;
            if (run == STABLE && $countones(dig) == 1) begin
                for (int i = 0; i < 4; i++) if (dig[i]) begin
                    m_code[i] = dec(seg);
                    m_seen[i] = 1;
                end
                if (m_seen == 4'hF) begin
                    m_bcd = {m_code[3], m_code[2], m_code[1], m_code[0]};
                    m_err = 0;
                    for (int i = 0; i < 4; i++) if (m_code[i] == 4'hE) m_err = 1;
                    m_valid = 1;
                    m_seen = '0;
                end
            end
        end
    end
    always @(posedge clk) begin
        #1;
        chk("bcd", 32'(bcd), 32'(m_bcd));
        chk("err", 32'(err), 32'(m_err));
        chk("valid", 32'(valid), 32'(m_valid));
        if (valid === 1'b1) begin
            vcnt++;
            vedge = ecnt;
        end
    end
    task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
        dig = d;
        seg = s;
        repeat (n) @(negedge clk);
    endtask
    task automatic frame(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c, input logic [6:0] e);
        hold(4'b0001, a, STABLE);
        hold(4'b0010, b, STABLE);
        hold(4'b0100, c, STABLE);
        hold(4'b1000, e, STABLE);
    endtask
    int v0, s0;
    initial begin
        rst = 1;
        dig = 4'($urandom);
        seg = 7'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        rst = 0;
        v0 = vcnt;
        hold(4'b0000, 7'd0, 3);
        chk("rst_novalid", 32'(vcnt - v0), 32'd0);
        v0 = vcnt;
        s0 = ecnt;
        frame(S4, S3, S2, S1);
        chk("nom_count", 32'(vcnt - v0), 32'd1);
        chk("nom_edge", 32'(vedge - s0 - 1), 32'd15);
        chk("nom_bcd", 32'(bcd), 32'h1234);
        chk("nom_model", 32'(m_bcd), 32'h1234);
        chk("nom_err", 32'(err), 32'h0);
        hold(4'b0000, 7'd0, 2);
        v0 = vcnt;
        hold(4'b0001, S4, 4);
        hold(4'b0010, S3, 4);
        hold(4'b0100, S2, 3);
        hold(4'b1000, S1, 4);
        chk("glitch_novalid", 32'(vcnt - v0), 32'd0);
        hold(4'b0100, S2, 4);
        chk("glitch_valid", 32'(vcnt - v0), 32'd1);
        chk("glitch_bcd", 32'(bcd), 32'h1234);
        hold(4'b0000, 7'd0, 2);
        frame(S9, S0, 7'b1000000, 7'b0000000);
        chk("inv_bcd", 32'(bcd), 32'hFE09);
        chk("inv_err", 32'(err), 32'h1);
        chk("inv_model", 32'({m_err, m_bcd}), 32'h1FE09);
        hold(4'b0000, 7'd0, 2);
        frame(S4, S3, S2, S1);
        chk("clean_err", 32'(err), 32'h0);
        hold(4'b0000, 7'd0, 2);
        v0 = vcnt;
        hold(4'b0011, S5, 8);
        hold(4'b0100, S2, 4);
        hold(4'b1000, S1, 4);
        chk("nonhot_novalid", 32'(vcnt - v0), 32'd0);
        hold(4'b0001, S5, 4);
        hold(4'b0001, S7, 4);
        hold(4'b0010, S3, 4);
        chk("ovr_valid", 32'(vcnt - v0), 32'd1);
        chk("ovr_bcd", 32'(bcd), 32'h1237);
        hold(4'b0000, 7'd0, 2);
        v0 = vcnt;
        hold(4'b0001, S4, 4);
        hold(4'b0010, S3, 4);
        rst = 1;
        hold(4'b0000, 7'd0, 1);
        rst = 0;
        hold(4'b0100, S2, 4);
        hold(4'b1000, S1, 4);
        chk("midrst_novalid", 32'(vcnt - v0), 32'd0);
        chk("midrst_bcd", 32'(bcd), 32'h0);
        hold(4'b0001, S4, 4);
        hold(4'b0010, S3, 4);
        chk("midrst_valid", 32'(vcnt - v0), 32'd1);
        chk("midrst_bcd2", 32'(bcd), 32'h1234);
        hold(4'b0000, 7'd0, 2);
        v0 = vcnt;
        hold(4'b0001, S9, 4);
        hold(4'b0010, S9, 4);
        hold(4'b0100, S9, 4);
        hold(4'b1000, S9, 3);
        rst = 1;
        hold(4'b1000, S9, 1);
        rst = 0;
        hold(4'b0000, 7'd0, 3);
        chk("rstwin_novalid", 32'(vcnt - v0), 32'd0);
        chk("rstwin_bcd", 32'(bcd), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
